// File: rtl/cpu_bus_master_pkg.sv
// Shared definitions for the CPU configuration bus initiator: cell config
// payload, FSM state encoding and the latched request record.
package cpu_bus_master_pkg;

  localparam int unsigned CPU_ADDR_W = 12;
  localparam int unsigned CELL_FWD_W = 4;
  localparam int unsigned CELL_VPI_W = 8;

  // Forwarding/VPI table entry carried on the configuration bus data lines
  typedef struct packed {
    logic [CELL_FWD_W-1:0] fwd;
    logic [CELL_VPI_W-1:0] vpi;
  } CellCfgType;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } CpuBusState;

  // Request captured at accept and held for the whole bus cycle
  typedef struct packed {
    logic                  write;
    logic [CPU_ADDR_W-1:0] addr;
    CellCfgType            wdata;
  } CpuBusReq;

  // Counter width able to hold n-1 (never narrower than one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_watchdog.sv
// Loadable down-counter used as the acknowledge watchdog; expired_c is high
// once the count has run down to zero.
module cpu_bus_watchdog
  import cpu_bus_master_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = cnt_width(LIMIT);

  logic [CNT_W-1:0] cnt;

  // Reload to LIMIT-1 so expiry lands on the LIMIT-th counted cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LIMIT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/cpu_bus_master.sv
// Initiator for the 12-bit CPU configuration bus. Turns single local read /
// write requests into Intel or Motorola style sel/strobe cycles and waits on
// the peripheral's active-low rdy_Dtack.
// Optional feature macro: CPU_BUS_TIMEOUT_EN adds a per-phase acknowledge
// watchdog (cpu_bus_watchdog) and the rsp_timeout indication.
module cpu_bus_master
  import cpu_bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_intel,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [CPU_ADDR_W-1:0] req_addr,
  input  CellCfgType            req_wdata,
  output logic                  rsp_valid,
  output CellCfgType            rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  cpu_busmode,
  output logic [CPU_ADDR_W-1:0] cpu_addr,
  output logic                  cpu_sel,
  output CellCfgType            cpu_datain,
  output logic                  cpu_rd_DS,
  output logic                  cpu_wr_RW,
  input  CellCfgType            cpu_dataout,
  input  logic                  cpu_rdy_Dtack
);

  localparam int unsigned SETUP_W = cnt_width(SETUP_CYCLES);

  if ((SETUP_CYCLES < 1) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("cpu_bus_master: need SETUP_CYCLES >= 1 and TIMEOUT_CYCLES >= 2");
  end

  CpuBusState         state;
  CpuBusReq           req_q;
  logic [SETUP_W-1:0] setup_cnt;
  logic               ack_c;
  logic               strobe_to_c;
  logic               release_to_c;

  assign ack_c      = !cpu_rdy_Dtack;
  assign cpu_addr   = req_q.addr;
  assign cpu_datain = req_q.wdata;

`ifdef CPU_BUS_TIMEOUT_EN
  logic wd_load_c;
  logic wd_en_c;
  logic wd_expired_c;

  // Arm during SETUP for the strobe phase, re-arm on leaving STROBE for RELEASE
  assign wd_load_c = (state == SETUP) || ((state == STROBE) && (ack_c || wd_expired_c));
  assign wd_en_c   = (state == STROBE) || (state == RELEASE);

  cpu_bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wd_load_c),
    .en        (wd_en_c),
    .expired_c (wd_expired_c)
  );

  // An acknowledge in the final watchdog cycle still wins over the timeout
  assign strobe_to_c  = (state == STROBE) && wd_expired_c;
  assign release_to_c = (state == RELEASE) && wd_expired_c;

  // Timeout flag travels with rsp_valid and is held until the next response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_timeout <= 1'b0;
    end else if ((state == STROBE) && (ack_c || wd_expired_c)) begin
      rsp_timeout <= !ack_c;
    end
  end
`else
  assign strobe_to_c  = 1'b0;
  assign release_to_c = 1'b0;
  assign rsp_timeout  = 1'b0;
`endif

  // Bus-cycle sequencer; every bus and response output is a flop here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      setup_cnt   <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      cpu_busmode <= 1'b1;
      cpu_sel     <= 1'b1;
      cpu_rd_DS   <= 1'b1;
      cpu_wr_RW   <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q       <= CpuBusReq'{write: req_write, addr: req_addr, wdata: req_wdata};
            cpu_busmode <= cfg_intel;
            cpu_sel     <= 1'b0;
            // Motorola direction is valid from SETUP onwards; Intel keeps it idle
            cpu_wr_RW   <= cfg_intel ? 1'b1 : !req_write;
            setup_cnt   <= SETUP_W'(SETUP_CYCLES - 1);
            req_ready   <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == '0) begin
            if (cpu_busmode && req_q.write) begin
              cpu_wr_RW <= 1'b0;
            end else begin
              cpu_rd_DS <= 1'b0;
            end
            state <= STROBE;
          end else begin
            setup_cnt <= setup_cnt - SETUP_W'(1);
          end
        end
        STROBE: begin
          if (ack_c || strobe_to_c) begin
            cpu_rd_DS <= 1'b1;
            cpu_wr_RW <= 1'b1;
            cpu_sel   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= (ack_c && !req_q.write) ? cpu_dataout : '0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          // Hold off the next accept until the peripheral drops its acknowledge
          if (cpu_rdy_Dtack || release_to_c) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master: table of bus transactions against a
// programmable responder, scoreboard on responses, plus hand-written reset
// abort and long-SETUP sequences (second instance with SETUP_CYCLES=3).
module tb_cpu_bus_master;
  import cpu_bus_master_pkg::*;

  localparam int unsigned TO_CYCLES = 16;

  typedef struct {
    logic       intel;
    logic       write;
    logic [11:0] addr;
    CellCfgType wdata;
    CellCfgType rsp_data;
    int         d;
    int         hold;
    CellCfgType exp_rdata;
  } vec_t;

  typedef struct {
    CellCfgType rdata;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  // main instance (SETUP_CYCLES = 1)
  logic        cfg_intel, req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  CellCfgType  req_wdata, rsp_rdata, datain, dataout;
  logic        rsp_valid, rsp_timeout;
  logic        busmode, sel, rd_DS, wr_RW, rdy_Dtack;
  logic [11:0] addr;

  // second instance (SETUP_CYCLES = 3)
  logic        b_cfg_intel, b_req_valid, b_req_ready, b_req_write;
  logic [11:0] b_req_addr;
  CellCfgType  b_req_wdata, b_rsp_rdata, b_datain, b_dataout;
  logic        b_rsp_valid, b_rsp_timeout;
  logic        b_busmode, b_sel, b_rd_DS, b_wr_RW, b_rdy_Dtack;
  logic [11:0] b_addr;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  // responder state
  int         r_delay, r_hold, scnt, hold_left;
  CellCfgType r_data;
  logic       tb_strobe;

  always #5 clk = ~clk;

  cpu_bus_master #(.SETUP_CYCLES(1), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_intel(cfg_intel), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .cpu_busmode(busmode), .cpu_addr(addr),
    .cpu_sel(sel), .cpu_datain(datain), .cpu_rd_DS(rd_DS), .cpu_wr_RW(wr_RW),
    .cpu_dataout(dataout), .cpu_rdy_Dtack(rdy_Dtack)
  );

  cpu_bus_master #(.SETUP_CYCLES(3), .TIMEOUT_CYCLES(TO_CYCLES)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_intel(b_cfg_intel), .req_valid(b_req_valid),
    .req_ready(b_req_ready), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_timeout(b_rsp_timeout), .cpu_busmode(b_busmode), .cpu_addr(b_addr),
    .cpu_sel(b_sel), .cpu_datain(b_datain), .cpu_rd_DS(b_rd_DS), .cpu_wr_RW(b_wr_RW),
    .cpu_dataout(b_dataout), .cpu_rdy_Dtack(b_rdy_Dtack)
  );

  // Responder: ack low after r_delay observed strobe cycles (0 = already low
  // once sel drops), then held low for r_hold cycles after sel releases.
  assign tb_strobe = busmode ? (!rd_DS || !wr_RW) : !rd_DS;
  assign rdy_Dtack = !((!sel && (scnt >= r_delay)) || (hold_left > 0));
  assign dataout   = r_data;
  assign b_dataout = 12'h69A;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt      <= 0;
      hold_left <= 0;
    end else if (!sel) begin
      if (tb_strobe) scnt <= scnt + 1;
      if (!rdy_Dtack) hold_left <= r_hold;
    end else begin
      scnt <= 0;
      if (hold_left > 0) hold_left <= hold_left - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response scoreboard and idle-bus protocol checks
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        end
      end
      if (req_ready) chk("idle_bus_sel_rd_wr_ack", 32'({sel, rd_DS, wr_RW, rdy_Dtack}), 32'hF);
    end
  end

  // One transaction on the main instance; called at a negedge
  task automatic run_vec(input vec_t v, input logic exp_to, input int exp_strobe);
    int   cyc, setup_n, strobe_n, rel_n, rsp_n, rsp_cyc;
    logic bad_dir, bad_addr, done;
    exp_t e;
    setup_n = 0; strobe_n = 0; rel_n = 0; rsp_n = 0; rsp_cyc = 0;
    bad_dir = 1'b0; bad_addr = 1'b0; done = 1'b0;
    r_delay = v.d; r_hold = v.hold; r_data = v.rsp_data;
    cfg_intel = v.intel; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    e.rdata = v.exp_rdata;
    e.to    = exp_to;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (!sel) begin
        if (busmode !== v.intel || addr !== v.addr || datain !== v.wdata) bad_addr = 1'b1;
        if (tb_strobe) strobe_n++;
        else if (strobe_n == 0) setup_n++;
        if (v.intel) begin
          if (v.write ? !rd_DS : !wr_RW) bad_dir = 1'b1;
        end else if (wr_RW !== !v.write) begin
          bad_dir = 1'b1;
        end
      end else if (!req_ready) begin
        rel_n++;
      end
      if (rsp_valid) begin
        rsp_n++;
        rsp_cyc = cyc;
      end
      if (req_ready) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("return_to_idle", 32'(done), 32'd1);
    chk("setup_cycles", 32'(setup_n), 32'd1);
    chk("strobe_cycles", 32'(strobe_n), 32'(exp_strobe));
    chk("release_cycles", 32'(rel_n), exp_to ? 32'd1 : 32'(v.hold + 1));
    chk("rsp_valid_count", 32'(rsp_n), 32'd1);
    chk("rsp_valid_cycle", 32'(rsp_cyc), 32'(exp_strobe + 2));
    chk("strobe_direction_ok", 32'(bad_dir), 32'd0);
    chk("addr_data_mode_stable", 32'(bad_addr), 32'd0);
    chk("rsp_rdata_held", 32'(rsp_rdata), 32'(v.exp_rdata));
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   setup_n;
    logic got, mode_ok;

    vecs[0] = '{1'b1, 1'b1, 12'h0A5, 12'h53C, 12'h000, 2, 0, 12'h000};
    vecs[1] = '{1'b0, 1'b0, 12'hFFF, 12'h000, 12'h8FF, 1, 0, 12'h8FF};
    vecs[2] = '{1'b1, 1'b0, 12'h123, 12'h222, 12'hA55, 0, 3, 12'hA55};
    vecs[3] = '{1'b0, 1'b1, 12'h000, 12'hF00, 12'h777, 0, 3, 12'h000};
    vecs[4] = '{1'b1, 1'b0, 12'h7FF, 12'h111, 12'h180, 4, 1, 12'h180};
    vecs[5] = '{1'b0, 1'b0, 12'h800, 12'h0C3, 12'h001, 0, 0, 12'h001};

    rst_n = 1'b0;
    cfg_intel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    b_cfg_intel = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0;
    b_req_wdata = '0; b_rdy_Dtack = 1'b1;
    r_delay = 0; r_hold = 0; r_data = '0;

    #12;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_datain", 32'(datain), 32'd0);
    chk("rst_busmode", 32'(busmode), 32'd1);
    chk("rst_sel_rd_wr", 32'({sel, rd_DS, wr_RW}), 32'h7);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // table-driven transactions (2 and 3 follow each other back-to-back)
    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, vecs[i].d + 1);

`ifdef CPU_BUS_TIMEOUT_EN
    v = '{1'b1, 1'b0, 12'h321, 12'h000, 12'hEEE, 1000, 0, 12'h000};
    run_vec(v, 1'b1, TO_CYCLES);
    v = '{1'b0, 1'b0, 12'h0F0, 12'h000, 12'hBCD, 15, 0, 12'hBCD};
    run_vec(v, 1'b0, 16);
`endif

    // reset while the strobe is active: immediate release, no response
    r_delay = 1000; r_hold = 0; r_data = 12'h5A5;
    cfg_intel = 1'b0; req_write = 1'b0; req_addr = 12'h3C3; req_wdata = '0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (tb_strobe) got = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reached_strobe", 32'(got), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sel_rd_wr", 32'({sel, rd_DS, wr_RW}), 32'h7);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_addr", 32'(addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    v = '{1'b1, 1'b1, 12'h5AA, 12'hC33, 12'h000, 1, 0, 12'h000};
    run_vec(v, 1'b0, 2);

    // SETUP_CYCLES=3 with cfg_intel toggling during SETUP
    chk("s3_ready", 32'(b_req_ready), 32'd1);
    b_cfg_intel = 1'b1; b_req_write = 1'b0; b_req_addr = 12'h456; b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    setup_n = 0; got = 1'b0; mode_ok = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (b_busmode !== 1'b1) mode_ok = 1'b0;
      if (!b_rd_DS || !b_wr_RW) got = 1'b1;
      else begin
        if (!b_sel) setup_n++;
        b_cfg_intel = ~b_cfg_intel;
        @(negedge clk);
      end
    end
    chk("s3_strobe_seen", 32'(got), 32'd1);
    chk("s3_setup_cycles", 32'(setup_n), 32'd3);
    chk("s3_intel_read_strobe", 32'({b_rd_DS, b_wr_RW}), 32'h1);
    b_rdy_Dtack = 1'b0;
    @(negedge clk);
    chk("s3_rsp_valid", 32'(b_rsp_valid), 32'd1);
    chk("s3_rsp_rdata", 32'(b_rsp_rdata), 32'h69A);
    chk("s3_sel_released", 32'(b_sel), 32'd1);
    b_rdy_Dtack = 1'b1;
    @(negedge clk);
    chk("s3_back_idle", 32'(b_req_ready), 32'd1);
    chk("s3_busmode_latched", 32'(mode_ok && b_busmode), 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Synthesizable initiator for the 12-bit-address CPU configuration bus: converts single read/write requests from a local command port into Intel- or Motorola-style bus cycles with sel/strobe handshaking against a peripheral's rdy_Dtack. It is the driving end of the `CpuInterface` `Test` modport, used by on-chip management logic and the bench to program cell forwarding/VPI tables in the switch.

## Interface
Parameters:
- SETUP_CYCLES, 1: cycles addr/sel/datain are stable before the strobe asserts (>=1).
- TIMEOUT_CYCLES, 16: acknowledge watchdog limit per phase (>=2; only used with `CPU_BUS_TIMEOUT_EN`).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_intel  input  1  bus style: 1 = Intel, 0 = Motorola; sampled at request accept.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; transfer when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  12  target address.
- req_wdata  input  CellCfgType  write data.
- rsp_valid  output  1  one-cycle pulse: transaction finished.
- rsp_rdata  output  CellCfgType  read data (0 for writes/timeouts); held until next rsp_valid.
- rsp_timeout  output  1  qualifies rsp_valid: no acknowledge.
- cpu  modport  CpuInterface.Test  drives busmode, addr, sel, datain, rd_DS, wr_RW; samples dataout, rdy_Dtack.

## Operation
- Bus signalling (all strobes and sel active-low; all bus outputs registered):
  - Intel: rd_DS = read strobe, wr_RW = write strobe.
  - Motorola: rd_DS = data strobe; wr_RW = direction (1 read, 0 write), driven from SETUP on.
  - rdy_Dtack low = acknowledge, both modes.
- States: IDLE, SETUP, STROBE, RELEASE.
  - IDLE: req_ready=1; on accept latch write/addr/wdata/cfg_intel, drive busmode, addr, datain, sel=0; go SETUP.
  - SETUP: count SETUP_CYCLES; then assert strobe; go STROBE.
  - STROBE: wait for rdy_Dtack==0. On the sampling cycle capture dataout (reads), deassert strobe and sel, go RELEASE.
  - RELEASE: rsp_valid=1 on its first cycle. Stay until rdy_Dtack==1, then IDLE. wr_RW returns to 1.
- A new request is never accepted before the peripheral releases rdy_Dtack.
- cfg_intel changes mid-transaction have no effect until the next accept.
- If rdy_Dtack is already low on entry to STROBE, it is taken as the acknowledge.
- Reset, including mid-transaction: all outputs go immediately to reset values. State returns to IDLE. No rsp_valid is generated for the aborted cycle.

## Timing
- Reset values:
  - addr=0, datain=0, busmode=1.
  - sel=1, rd_DS=1, wr_RW=1.
  - rsp_valid=0, rsp_rdata=0, rsp_timeout=0.
  - req_ready=1 once rst_n is high.
- Minimum transaction, SETUP_CYCLES=1, ack already low at STROBE:
  - T0 accept.
  - T1 SETUP (sel low).
  - T2 strobe low, ack sampled.
  - T3 RELEASE with rsp_valid.
  - T4 IDLE, req_ready=1.
- Each extra SETUP cycle or ack-wait cycle adds one cycle.
- rsp_rdata updates in the same cycle rsp_valid rises.

## Configuration
- `CPU_BUS_TIMEOUT_EN` defined:
  - A watchdog counts cycles in STROBE and in RELEASE separately.
  - STROBE reaching TIMEOUT_CYCLES without ack: release bus, go RELEASE, rsp_valid with rsp_timeout=1 and rsp_rdata=0.
  - RELEASE reaching TIMEOUT_CYCLES: return to IDLE regardless of rdy_Dtack.
- Not defined:
  - No counter is built; rsp_timeout is tied 0.
  - STROBE and RELEASE wait indefinitely.

## Structure
- Shared definitions package: CellCfgType (existing), enum CpuBusState {IDLE, SETUP, STROBE, RELEASE}, and a packed CpuBusReq struct {write, addr, wdata}.
- Optional sub-module `cpu_bus_watchdog`: loadable down-counter with an expired flag, instantiated only under `CPU_BUS_TIMEOUT_EN`.

## Test plan
- Intel write, addr 12'h0A5, wdata {FWD=4'b0101, VPI=8'h3C}, responder acks after 2 cycles:
  - wr_RW low exactly during STROBE, rd_DS stays 1.
  - rsp_valid once, rsp_timeout=0.
- Motorola read of addr 12'hFFF, responder returns {FWD=4'b1000, VPI=8'hFF}:
  - wr_RW=1 from SETUP, rd_DS low until ack.
  - rsp_rdata equals the returned value.
- Back-to-back requests, ack held low 3 cycles into RELEASE:
  - Second accept only after rdy_Dtack returns high.
  - No overlap of sel between cycles.
- With `CPU_BUS_TIMEOUT_EN`, TIMEOUT_CYCLES=16, no ack:
  - Strobe released after 16 STROBE cycles.
  - rsp_valid with rsp_timeout=1, rsp_rdata=0.
  - req_ready returns high.
- rst_n asserted while in STROBE:
  - sel, rd_DS, wr_RW go to 1 asynchronously.
  - No rsp_valid.
  - Next request completes normally.
- SETUP_CYCLES=3, cfg_intel toggled during SETUP:
  - Strobe asserts exactly 3 cycles after sel.
  - busmode keeps the value latched at accept.
